ex_commit: RTL
==============

# ex_commit

Commit-stage exception and CSR-write controller. It accepts retiring instructions from the memory stage through a valid/ready handshake and resolves exceptions and interrupts by fixed priority. It drives the CSR register file's write port, exception port and ertn port, and issues a multi-cycle pipeline flush with the redirect PC taken from the CSR file.

## Interface
- FLUSH_CYCLES, 2, number of cycles `flush` stays high per redirect; legal range 1..15.

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  retiring instruction present
- in_ready  out  1  block can accept this cycle
- in_pc  in  32  instruction PC
- in_exc  in  5  exception flags: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE
- in_vaddr  in  32  faulting data address (ALE)
- in_ertn  in  1  instruction is ertn
- in_csr_op  in  2  00 none, 01 csrrd, 10 csrwr, 11 csrxchg
- in_csr_addr  in  14  CSR number
- in_csr_mask  in  32  xchg mask (rj value)
- in_csr_wdata  in  32  write data (rd value)
- has_int  in  1  pending enabled interrupt from CSR file
- ex_entryPC  in  32  exception entry from CSR file
- new_pc  in  32  ertn return PC from CSR file
- csr_we  out  1  CSR write strobe
- csr_waddr  out  14  CSR write address
- csr_wmask  out  32  CSR write mask
- csr_wdata  out  32  CSR write data
- ex_en  out  1  exception commit strobe
- ecode  out  8  exception code
- esubcode  out  1  exception subcode
- ex_pc  out  32  PC recorded into ERA
- ex_vaddr  out  32  address recorded into BADV
- ertn_flush  out  1  ertn commit strobe
- flush  out  1  kill younger pipeline stages
- flush_pc  out  32  fetch redirect target
- commit_valid  out  1  instruction retired without exception
- commit_pc  out  32  PC of retired instruction

## Operation
- Accept on `in_valid && in_ready`. Unaccepted beats have no effect.
- Cause priority at acceptance: has_int > ADEF > INE > SYS > BRK > ALE.
- Cause codes: INT ecode 0x00; ADEF 0x08, esubcode 0; INE 0x0D; SYS 0x0B; BRK 0x0C; ALE 0x09, with ex_vaddr = in_vaddr.
- For every other cause, ex_vaddr = 0.
- esubcode is 0 for every cause.
- Exception taken (any cause):
  - ex_en = 1 and ex_pc = in_pc.
  - CSR write and ertn are suppressed.
  - flush_pc = ex_entryPC, sampled at acceptance.
- ertn without exception: ertn_flush = 1 and flush_pc = new_pc, sampled at acceptance. An ertn that also carries a CSR op performs no CSR write.
- csrwr without exception:
  - csr_we = 1, csr_waddr = in_csr_addr, csr_wdata = in_csr_wdata, csr_wmask = 0xFFFFFFFF.
- csrxchg without exception: as csrwr, but csr_wmask = in_csr_mask.
- csrrd and none: no write.
- commit_valid = 1 when no exception is taken, including ertn. commit_pc = in_pc.
- FSM states:
  - RUN: in_ready = 1.
  - BUBBLE: in_ready = 0 for one cycle, so the CSR write lands before the next ex_entryPC/new_pc sample.
  - FLUSH: in_ready = 1; incoming beats are accepted and discarded with no outputs. Down-counter starts at FLUSH_CYCLES−1.
- FSM transitions:
  - RUN → FLUSH on an accepted exception or ertn.
  - RUN → BUBBLE on an accepted csrwr/csrxchg.
  - Otherwise RUN stays in RUN.
  - BUBBLE → RUN.
  - FLUSH → RUN when the counter reaches 0.
  - FSM state width is 2 bits.

## Timing
- All outputs are registered. Strobes pulse for exactly one cycle, in the cycle after the accepting edge: ex_en, ertn_flush, csr_we, commit_valid.
- Data outputs hold their last value between strobes: ecode, esubcode, ex_pc, ex_vaddr, csr_w*, commit_pc, flush_pc.
- `flush` rises in the same cycle as ex_en/ertn_flush and stays high for exactly FLUSH_CYCLES cycles. flush_pc is stable throughout.
- With FLUSH_CYCLES = 1, the instruction presented in the cycle after the redirect is accepted normally.
- Back-to-back non-CSR, non-exception instructions retire at 1 per cycle.
- Reset, including mid-FLUSH or mid-BUBBLE:
  - State returns to RUN and the counter to 0.
  - Every output is 0, except in_ready, which is 1 once rstn deasserts.
- has_int is sampled only at acceptance. An interrupt that rises during FLUSH/BUBBLE is taken on the next accepted instruction.

## Test plan
- Plain retire: 3 back-to-back beats, pc 0x1C000000/04/08, no exc → commit_valid 3 consecutive cycles, matching commit_pc; no ex_en/flush.
- Exception priority: in_exc=5'b10110 with has_int=0 at pc 0x1C000010, ex_entryPC=0x1C008000 → ecode 0x0D; ex_pc 0x1C000010; flush high 2 cycles with flush_pc 0x1C008000; no csr_we.
- Interrupt over csrwr: has_int=1 with csrwr addr 0x30 → ecode 0x00; csr_we stays 0; commit_valid 0.
- csrxchg: addr 0x04, mask 0x00001FFF, wdata 0x00000800 → csr_we pulse with those values; in_ready low exactly one cycle after; next beat accepted one cycle later.
- ertn with FLUSH_CYCLES=3: new_pc=0x1C000104 → ertn_flush 1 cycle; flush 3 cycles with flush_pc 0x1C000104; 3 beats offered during flush are discarded; the 4th beat retires.
- Reset mid-flush: assert rstn low on the second flush cycle → flush, ex_en and commit_valid are 0 immediately; after release, in_ready = 1 and the next beat retires normally.

Source files
------------

// File: rtl/ex_commit_if.sv
// Retire handshake from memory stage into commit stage.
// Master drives the beat; slave returns in_ready.
interface ex_commit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_exc;
  logic [31:0] in_vaddr;
  logic        in_ertn;
  logic [1:0]  in_csr_op;
  logic [13:0] in_csr_addr;
  logic [31:0] in_csr_mask;
  logic [31:0] in_csr_wdata;

  modport master (
    output in_valid, in_pc, in_exc, in_vaddr,
    output in_ertn, in_csr_op, in_csr_addr,
    output in_csr_mask, in_csr_wdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_exc, in_vaddr,
    input  in_ertn, in_csr_op, in_csr_addr,
    input  in_csr_mask, in_csr_wdata,
    output in_ready
  );
endinterface

// File: rtl/ex_commit.sv
// Commit stage: exception/interrupt resolution, CSR write port,
// ertn handling and multi-cycle redirect flush.
module ex_commit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  ex_commit_if.slave  mem,
  input  logic        has_int,
  input  logic [31:0] ex_entryPC,
  input  logic [31:0] new_pc,
  output logic        csr_we,
  output logic [13:0] csr_waddr,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wdata,
  output logic        ex_en,
  output logic [7:0]  ecode,
  output logic        esubcode,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_vaddr,
  output logic        ertn_flush,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        commit_valid,
  output logic [31:0] commit_pc
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_BUBBLE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic        r_we;
  logic [13:0] r_waddr;
  logic [31:0] r_wmask;
  logic [31:0] r_wdata;
  logic        r_ex_en;
  logic [7:0]  r_ecode;
  logic        r_esub;
  logic [31:0] r_ex_pc;
  logic [31:0] r_ex_va;
  logic        r_ertn;
  logic        r_flush;
  logic [31:0] r_fpc;
  logic        r_cv;
  logic [31:0] r_cpc;

  logic        w_take;
  logic        w_exc;
  logic [7:0]  w_ecode;
  logic [31:0] w_vaddr;

  assign w_take = mem.in_valid & r_ready & (r_state == S_RUN);
  assign w_exc  = has_int | (|mem.in_exc);

  // Fixed-priority cause select; several flags may be set at once.
  always_comb begin
    w_ecode = 8'h00;
    w_vaddr = 32'h0;
    priority case (1'b1)
      has_int:       w_ecode = 8'h00;
      mem.in_exc[0]: w_ecode = 8'h08;
      mem.in_exc[1]: w_ecode = 8'h0D;
      mem.in_exc[2]: w_ecode = 8'h0B;
      mem.in_exc[3]: w_ecode = 8'h0C;
      mem.in_exc[4]: begin
        w_ecode = 8'h09;
        w_vaddr = mem.in_vaddr;
      end
      default: ;
    endcase
  end

  // Control FSM with registered strobes and held data outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_RUN;
      r_cnt   <= 4'd0;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_waddr <= 14'h0;
      r_wmask <= 32'h0;
      r_wdata <= 32'h0;
      r_ex_en <= 1'b0;
      r_ecode <= 8'h0;
      r_esub  <= 1'b0;
      r_ex_pc <= 32'h0;
      r_ex_va <= 32'h0;
      r_ertn  <= 1'b0;
      r_flush <= 1'b0;
      r_fpc   <= 32'h0;
      r_cv    <= 1'b0;
      r_cpc   <= 32'h0;
    end else begin
      r_we    <= 1'b0;
      r_ex_en <= 1'b0;
      r_ertn  <= 1'b0;
      r_cv    <= 1'b0;
      unique case (r_state)
        S_RUN: begin
          if (w_take) begin
            if (w_exc) begin
              r_ex_en <= 1'b1;
              r_ecode <= w_ecode;
              r_esub  <= 1'b0;
              r_ex_pc <= mem.in_pc;
              r_ex_va <= w_vaddr;
              r_fpc   <= ex_entryPC;
              r_flush <= 1'b1;
              r_cnt   <= CNT_INIT;
              r_state <= S_FLUSH;
            end else begin
              r_cv  <= 1'b1;
              r_cpc <= mem.in_pc;
              if (mem.in_ertn) begin
                r_ertn  <= 1'b1;
                r_fpc   <= new_pc;
                r_flush <= 1'b1;
                r_cnt   <= CNT_INIT;
                r_state <= S_FLUSH;
              end else if (mem.in_csr_op[1]) begin
                r_we    <= 1'b1;
                r_waddr <= mem.in_csr_addr;
                r_wdata <= mem.in_csr_wdata;
                r_wmask <= mem.in_csr_op[0]
                         ? mem.in_csr_mask
                         : 32'hFFFF_FFFF;
                r_ready <= 1'b0;
                r_state <= S_BUBBLE;
              end
            end
          end
        end
        S_BUBBLE: begin
          r_ready <= 1'b1;
          r_state <= S_RUN;
        end
        S_FLUSH: begin
          if (r_cnt == 4'd0) begin
            r_flush <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign mem.in_ready  = r_ready;
  assign csr_we        = r_we;
  assign csr_waddr     = r_waddr;
  assign csr_wmask     = r_wmask;
  assign csr_wdata     = r_wdata;
  assign ex_en         = r_ex_en;
  assign ecode         = r_ecode;
  assign esubcode      = r_esub;
  assign ex_pc         = r_ex_pc;
  assign ex_vaddr      = r_ex_va;
  assign ertn_flush    = r_ertn;
  assign flush         = r_flush;
  assign flush_pc      = r_fpc;
  assign commit_valid  = r_cv;
  assign commit_pc     = r_cpc;

endmodule
